fifo_read_ctrl: RTL and testbench

Read-side controller for the 32-entry FIFO memory. It uses the write side's occupancy count to issue one-word read strobes to the storage array and captures the returned data in a 2-entry output buffer. It presents that data on a valid/ready stream with full throughput and no bubbles. It is the drain-end counterpart of the write-side status logic and never issues a read when the FIFO is empty, so underflow cannot occur.

---
 rtl/fifo_read_ctrl.sv | 108 ++++++++++
 tb/tb_fifo_read_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the FIFO storage array: issues read strobes from the
// write side's occupancy count and buffers returned words in a 2-entry skid buffer.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int PTR_WIDTH  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PTR_WIDTH-1:0]     count,
  output logic                     rd,
  output logic [$clog2(DEPTH)-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     drained
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  buf_state_e            buf_cnt_q, buf_cnt_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  logic       pop;
  logic       push;
  logic [2:0] occ;

  assign pop  = m_valid & m_ready;
  assign push = inflight_q;
  // Occupancy the buffer will have after this cycle, counting the word still in flight.
  assign occ  = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_cnt_q  <= BUF_EMPTY;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      // NOTE: data registers are reset too so m_data reads 0 out of reset.
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      buf_cnt_q  <= buf_cnt_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    buf_cnt_d = buf_cnt_q;
    unique case (buf_cnt_q)
      BUF_EMPTY: if (push) buf_cnt_d = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)      buf_cnt_d = BUF_TWO;
        else if (!push && pop) buf_cnt_d = BUF_EMPTY;
      end
      BUF_TWO:   if (pop && !push) buf_cnt_d = BUF_ONE;
      default:   buf_cnt_d = BUF_EMPTY;
    endcase
  end

  // Datapath: head always holds the oldest word, tail the younger one.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    rd_addr_d  = rd ? rd_addr_q + AW'(1) : rd_addr_q;
    inflight_d = rd;
    unique case (buf_cnt_q)
      BUF_EMPTY: if (push) head_d = rd_data;
      BUF_ONE: begin
        if (push && pop) head_d = rd_data;
        else if (push)   tail_d = rd_data;
      end
      BUF_TWO: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = rd_data;
        end
      end
      default: ;
    endcase
  end

  // Outputs; rd is held off while reset is asserted so no strobe escapes during reset.
  always_comb begin
    m_valid = (buf_cnt_q != BUF_EMPTY);
    rd      = rst_n & (count != '0) & (occ < 3'd2);
    drained = (count == '0) & ~inflight_q & (buf_cnt_q == BUF_EMPTY);
  end

  assign rd_addr = rd_addr_q;
  assign m_data  = head_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a behavioural write side and storage array.
module tb_fifo_read_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int PW    = 6;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] count;
  logic          rd;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          drained;

  logic          ld_en;
  logic [PW-1:0] ld_val;
  logic          wr_inc;
  logic [DW-1:0] mem [DEPTH];

  int tests;
  int fails;

  fifo_read_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .count   (count),
    .rd      (rd),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .drained (drained)
  );

  always #5 clk = ~clk;

  // Write side: registered count that drops by one the cycle after each rd.
  always @(posedge clk) begin
    if (ld_en) count <= ld_val;
    else       count <= count + {5'd0, wr_inc} - {5'd0, rd};
    if (rd) rd_data <= mem[rd_addr];
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; ld_en = 1'b1; ld_val = '0; wr_inc = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    ld_en = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; m_ready = 1'b1; ld_en = 1'b1; ld_val = 6'd5;
    @(negedge clk);
    ld_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (rd !== 1'b0 || m_valid !== 1'b0 || rd_addr !== 5'd0 || m_data !== 8'h00) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: rd=%b m_valid=%b rd_addr=%0d m_data=%h, want 0 0 0 00",
                 c, rd, m_valid, rd_addr, m_data);
      end
      if (c < 2) @(negedge clk);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (rd !== 1'b1 || drained !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: rd=%b drained=%b, want rd=1 drained=0", rd, drained);
    end
  endtask

  task automatic test_streaming();
    int n_rd = 0, n_out = 0, first_rd = -1, last_rd = -1, first_out = -1, last_out = -1;
    int drained_cyc = -1;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    #1;
    tests++;
    if (drained !== 1'b1 || rd !== 1'b0) begin
      fails++;
      $display("FAIL idle_drained: drained=%b rd=%b, want 1 0", drained, rd);
    end
    m_ready = 1'b1; ld_en = 1'b1; ld_val = 6'd32;
    @(negedge clk);
    ld_en = 1'b0;
    for (int c = 0; c < 41; c++) begin
      #1;
      if (rd) begin
        tests++;
        if (rd_addr !== 5'(n_rd)) begin
          fails++;
          $display("FAIL stream_addr: rd_addr=%0d, want %0d", rd_addr, n_rd);
        end
        if (first_rd < 0) first_rd = c;
        last_rd = c; n_rd++;
      end
      if (m_valid && m_ready) begin
        tests++;
        if (m_data !== 8'(n_out)) begin
          fails++;
          $display("FAIL stream_data: m_data=%h, want %h", m_data, 8'(n_out));
        end
        if (first_out < 0) first_out = c;
        last_out = c; n_out++;
      end
      if (drained && n_out == 32 && drained_cyc < 0) drained_cyc = c;
      @(negedge clk);
    end
    tests++;
    if (n_rd != 32 || first_rd != 0 || last_rd != 31) begin
      fails++;
      $display("FAIL stream_rd_run: n=%0d first=%0d last=%0d, want 32 0 31", n_rd, first_rd, last_rd);
    end
    tests++;
    if (n_out != 32 || first_out != 2 || last_out != 33) begin
      fails++;
      $display("FAIL stream_out_run: n=%0d first=%0d last=%0d, want 32 2 33", n_out, first_out, last_out);
    end
    // drained needs the buffer empty, so it rises the cycle after the final word is accepted.
    tests++;
    if (drained_cyc != 34) begin
      fails++;
      $display("FAIL stream_drained: cycle=%0d, want 34", drained_cyc);
    end
  endtask

  task automatic test_backpressure();
    int stall_rd = 0, n_out = 0, first_out = -1, last_out = -1;
    apply_reset();
    for (int i = 0; i < 10; i++) mem[i] = 8'(i);
    m_ready = 1'b0; ld_en = 1'b1; ld_val = 6'd10;
    @(negedge clk);
    ld_en = 1'b0;
    for (int c = 0; c < 30; c++) begin
      m_ready = (c >= 8);
      #1;
      if (c < 8) begin
        if (rd) stall_rd++;
        if (c >= 2) begin
          tests++;
          if (m_valid !== 1'b1 || m_data !== 8'h00) begin
            fails++;
            $display("FAIL bp_hold cyc%0d: m_valid=%b m_data=%h, want 1 00", c, m_valid, m_data);
          end
        end
      end
      if (m_valid && m_ready) begin
        tests++;
        if (m_data !== 8'(n_out)) begin
          fails++;
          $display("FAIL bp_data: m_data=%h, want %h", m_data, 8'(n_out));
        end
        if (first_out < 0) first_out = c;
        last_out = c; n_out++;
      end
      @(negedge clk);
    end
    tests++;
    if (stall_rd != 2) begin
      fails++;
      $display("FAIL bp_stall_reads: got %0d, want 2", stall_rd);
    end
    tests++;
    if (n_out != 10 || first_out != 8 || last_out != 17) begin
      fails++;
      $display("FAIL bp_run: n=%0d first=%0d last=%0d, want 10 8 17", n_out, first_out, last_out);
    end
  endtask

  task automatic test_wrap();
    int n_rd = 0, n_out = 0, wr_ptr = 32;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    m_ready = 1'b1; ld_en = 1'b1; ld_val = 6'd32;
    @(negedge clk);
    ld_en = 1'b0;
    for (int c = 0; c < 60; c++) begin
      wr_inc = 1'b0;
      if (wr_ptr < 40 && count < 6'd32) begin
        mem[wr_ptr % DEPTH] = 8'(wr_ptr);
        wr_inc = 1'b1;
        wr_ptr++;
      end
      #1;
      if (rd) begin
        tests++;
        if (rd_addr !== 5'(n_rd % DEPTH)) begin
          fails++;
          $display("FAIL wrap_addr read%0d: rd_addr=%0d, want %0d", n_rd, rd_addr, n_rd % DEPTH);
        end
        n_rd++;
      end
      if (m_valid && m_ready) begin
        tests++;
        if (m_data !== 8'(n_out)) begin
          fails++;
          $display("FAIL wrap_data: m_data=%h, want %h", m_data, 8'(n_out));
        end
        n_out++;
      end
      @(negedge clk);
    end
    wr_inc = 1'b0;
    tests++;
    if (n_rd != 40 || n_out != 40) begin
      fails++;
      $display("FAIL wrap_totals: reads=%0d words=%0d, want 40 40", n_rd, n_out);
    end
  endtask

  task automatic test_empty_boundary();
    int n_rd = 0, n_out = 0, wr_ptr = 0;
    apply_reset();
    m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      wr_inc = (c == 0 || c == 6);
      if (wr_inc) begin
        mem[wr_ptr] = 8'hA0 + 8'(wr_ptr);
        wr_ptr++;
      end
      #1;
      tests++;
      if (rd && count == 6'd0) begin
        fails++;
        $display("FAIL empty_rd cyc%0d: rd=1 with count=0, want rd=0", c);
      end
      if (rd) n_rd++;
      if (m_valid && m_ready) begin
        tests++;
        if (m_data !== 8'hA0 + 8'(n_out)) begin
          fails++;
          $display("FAIL empty_data: m_data=%h, want %h", m_data, 8'hA0 + 8'(n_out));
        end
        n_out++;
      end
      @(negedge clk);
    end
    wr_inc = 1'b0;
    tests++;
    if (n_rd != 2 || n_out != 2) begin
      fails++;
      $display("FAIL empty_totals: reads=%0d words=%0d, want 2 2", n_rd, n_out);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int i = 0; i < 5; i++) mem[i] = 8'h50 + 8'(i);
    m_ready = 1'b1; ld_en = 1'b1; ld_val = 6'd5;
    @(negedge clk);
    ld_en = 1'b0;
    #1;
    tests++;
    if (rd !== 1'b1) begin
      fails++;
      $display("FAIL mid_first_rd: rd=%b, want 1", rd);
    end
    @(negedge clk);
    rst_n = 1'b0; ld_en = 1'b1; ld_val = '0;
    @(negedge clk);
    rst_n = 1'b1; ld_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++;
      if (m_valid !== 1'b0 || drained !== 1'b1 || rd !== 1'b0) begin
        fails++;
        $display("FAIL mid_discard cyc%0d: m_valid=%b drained=%b rd=%b, want 0 1 0",
                 c, m_valid, drained, rd);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; m_ready = 1'b0; ld_en = 1'b1; ld_val = '0; wr_inc = 1'b0; rd_data = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_empty_boundary();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
